// File: rtl/dmem_pkg.sv
// Shared constants, word type and address helper for the MIPS data memory.
package dmem_pkg;

  localparam int unsigned DMEM_DATA_WIDTH = 32;
  localparam int unsigned DMEM_ADDR_WIDTH = 32;
  localparam int unsigned DMEM_DEPTH      = 64;
  localparam int unsigned DMEM_IDX_W      = $clog2(DMEM_DEPTH);

  typedef logic [DMEM_DATA_WIDTH-1:0] word_t;

  // True when no address bit above the word index is set (no aliasing allowed).
  function automatic logic addr_in_range(input logic [63:0] a, input int unsigned idx_w);
    return (a >> (idx_w + 2)) == 64'd0;
  endfunction

endpackage

// File: rtl/dmem_addr_dec.sv
// Byte-address decoder: word index, range check and alignment check.
module dmem_addr_dec
  import dmem_pkg::*;
#(
  parameter  int unsigned ADDR_WIDTH = DMEM_ADDR_WIDTH,
  parameter  int unsigned DEPTH      = DMEM_DEPTH,
  localparam int unsigned IDX_W      = $clog2(DEPTH)
) (
  input  logic [ADDR_WIDTH-1:0] a,
  output logic [IDX_W-1:0]      idx,
  output logic                  in_range,
  output logic                  misaligned
);

  // Byte offset bits [1:0] never select a word.
  assign idx        = a[IDX_W+1:2];
  assign in_range   = addr_in_range(64'(a), IDX_W);
  assign misaligned = |a[1:0];

endmodule

// File: rtl/data_memory.sv
// Word-organised data RAM: combinational read, posedge write, async clear.
// Optional macro DMEM_ERR_FLAG_EN adds a combinational err output flagging
// misaligned or out-of-range addresses.
module data_memory
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DMEM_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DMEM_ADDR_WIDTH,
  parameter int unsigned DEPTH      = DMEM_DEPTH
) (
  output logic [DATA_WIDTH-1:0] RD,
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] WD,
  input  logic                  WE,
  input  logic                  reset
`ifdef DMEM_ERR_FLAG_EN
  ,
  output logic                  err
`endif
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [IDX_W-1:0]      idx;
  logic                  in_range;
  logic                  misaligned;

  dmem_addr_dec #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_addr_dec (
    .a          (A),
    .idx        (idx),
    .in_range   (in_range),
    .misaligned (misaligned)
  );

  // Storage: cleared asynchronously; writes only for a definite WE=1 in range.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if ((WE === 1'b1) && in_range) begin
      mem[idx] <= WD;
    end
  end

  // Read path: zero latency, forced to zero out of range or in reset.
  always_comb begin
    RD = '0;
    if (!reset && in_range) begin
      RD = mem[idx];
    end
  end

`ifdef DMEM_ERR_FLAG_EN
  // Address error flag, independent of WE and suppressed during reset.
  always_comb begin
    err = 1'b0;
    if (!reset) begin
      err = misaligned || !in_range;
    end
  end
`else
  logic unused_misaligned;
  assign unused_misaligned = misaligned;
`endif

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory.
module tb_data_memory;
  import dmem_pkg::*;

  logic  clk;
  logic  reset;
  logic [DMEM_ADDR_WIDTH-1:0] A;
  word_t WD;
  logic  WE;
  word_t RD;
`ifdef DMEM_ERR_FLAG_EN
  logic  err;
`endif

  int n_cmp;
  int n_err;

  data_memory dut (
    .RD    (RD),
    .clk   (clk),
    .A     (A),
    .WD    (WD),
    .WE    (WE),
    .reset (reset)
`ifdef DMEM_ERR_FLAG_EN
    ,
    .err   (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, summary not printed");
    $fatal(1, "watchdog");
  end

  // Present inputs on the falling edge, clear of the active edge.
  task automatic drive(input logic [31:0] a, input logic [31:0] wd, input logic we);
    @(negedge clk);
    A  = a;
    WD = wd;
    WE = we;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    A = 32'h0; WD = 32'h0; WE = 1'b0;
    #1;
    n_cmp++;
    if (RD !== 32'h0) begin
      n_err++; $display("FAIL reset_rd: got %h expected %h", RD, 32'h0);
    end
`ifdef DMEM_ERR_FLAG_EN
    n_cmp++;
    if (err !== 1'b0) begin
      n_err++; $display("FAIL reset_err: got %b expected 0", err);
    end
`endif
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 64; i++) begin
      A = 32'(i * 4);
      #1;
      n_cmp++;
      if (RD !== 32'h0) begin
        n_err++; $display("FAIL clear_word%0d: got %h expected %h", i, RD, 32'h0);
      end
    end
  endtask

  task automatic test_write_enable();
    drive(32'h0, 32'hD, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    n_cmp++;
    if (RD !== 32'h0) begin
      n_err++; $display("FAIL we0_no_write: got %h expected %h", RD, 32'h0);
    end
    drive(32'h0, 32'hD, 1'b1);
    #1;
    n_cmp++;
    if (RD !== 32'h0) begin
      n_err++; $display("FAIL pre_edge_old: got %h expected %h", RD, 32'h0);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (RD !== 32'hD) begin
      n_err++; $display("FAIL we1_write: got %h expected %h", RD, 32'hD);
    end
    drive(32'h0, 32'hFF, 1'b0);
    @(posedge clk); #1;
    n_cmp++;
    if (RD !== 32'hD) begin
      n_err++; $display("FAIL we0_hold: got %h expected %h", RD, 32'hD);
    end
  endtask

  task automatic test_words();
    drive(32'h4, 32'hA5A5_0001, 1'b1);
    drive(32'hFC, 32'h1234_5678, 1'b1);
    drive(32'h4, 32'h0, 1'b0);
    #1;
    n_cmp++;
    if (RD !== 32'hA5A5_0001) begin
      n_err++; $display("FAIL word1: got %h expected %h", RD, 32'hA5A5_0001);
    end
`ifdef DMEM_ERR_FLAG_EN
    n_cmp++;
    if (err !== 1'b0) begin
      n_err++; $display("FAIL err_aligned: got %b expected 0", err);
    end
`endif
    A = 32'hFC; #1;
    n_cmp++;
    if (RD !== 32'h1234_5678) begin
      n_err++; $display("FAIL word63: got %h expected %h", RD, 32'h1234_5678);
    end
    A = 32'h0; #1;
    n_cmp++;
    if (RD !== 32'hD) begin
      n_err++; $display("FAIL word0_kept: got %h expected %h", RD, 32'hD);
    end
  endtask

  task automatic test_out_of_range();
    drive(32'h100, 32'hDEAD, 1'b1);
    #1;
    n_cmp++;
    if (RD !== 32'h0) begin
      n_err++; $display("FAIL oor_rd: got %h expected %h", RD, 32'h0);
    end
`ifdef DMEM_ERR_FLAG_EN
    n_cmp++;
    if (err !== 1'b1) begin
      n_err++; $display("FAIL oor_err: got %b expected 1", err);
    end
`endif
    drive(32'h8000_0004, 32'hBEEF, 1'b1);
    #1;
    n_cmp++;
    if (RD !== 32'h0) begin
      n_err++; $display("FAIL oor_high_rd: got %h expected %h", RD, 32'h0);
    end
    drive(32'h0, 32'h0, 1'b0);
    #1;
    n_cmp++;
    if (RD !== 32'hD) begin
      n_err++; $display("FAIL oor_no_alias0: got %h expected %h", RD, 32'hD);
    end
    A = 32'h4; #1;
    n_cmp++;
    if (RD !== 32'hA5A5_0001) begin
      n_err++; $display("FAIL oor_no_alias1: got %h expected %h", RD, 32'hA5A5_0001);
    end
  endtask

  task automatic test_misaligned();
    drive(32'h7, 32'h55, 1'b1);
`ifdef DMEM_ERR_FLAG_EN
    #1;
    n_cmp++;
    if (err !== 1'b1) begin
      n_err++; $display("FAIL mis_err: got %b expected 1", err);
    end
`endif
    drive(32'h4, 32'h0, 1'b0);
    #1;
    n_cmp++;
    if (RD !== 32'h55) begin
      n_err++; $display("FAIL mis_lands: got %h expected %h", RD, 32'h55);
    end
    A = 32'h6; #1;
    n_cmp++;
    if (RD !== 32'h55) begin
      n_err++; $display("FAIL mis_read: got %h expected %h", RD, 32'h55);
    end
  endtask

  task automatic test_back_to_back();
    drive(32'h8, 32'h1111_2222, 1'b1);
    drive(32'hC, 32'h3333_4444, 1'b1);
    drive(32'h8, 32'h0, 1'b0);
    #1;
    n_cmp++;
    if (RD !== 32'h1111_2222) begin
      n_err++; $display("FAIL b2b_word2: got %h expected %h", RD, 32'h1111_2222);
    end
    A = 32'hC; #1;
    n_cmp++;
    if (RD !== 32'h3333_4444) begin
      n_err++; $display("FAIL b2b_word3: got %h expected %h", RD, 32'h3333_4444);
    end
  endtask

  task automatic test_reset_mid();
    drive(32'hFC, 32'h0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (RD !== 32'h0) begin
      n_err++; $display("FAIL mid_reset_rd: got %h expected %h", RD, 32'h0);
    end
    A = 32'h7; WD = 32'h77; WE = 1'b1; #1;
`ifdef DMEM_ERR_FLAG_EN
    n_cmp++;
    if (err !== 1'b0) begin
      n_err++; $display("FAIL reset_err_mis: got %b expected 0", err);
    end
`endif
    @(posedge clk);
    #2;
    WE = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 64; i++) begin
      A = 32'(i * 4);
      #0.01;
      n_cmp++;
      if (RD !== 32'h0) begin
        n_err++; $display("FAIL post_reset_word%0d: got %h expected %h", i, RD, 32'h0);
      end
    end
    drive(32'h10, 32'hCAFE_F00D, 1'b1);
    @(posedge clk); #1;
    n_cmp++;
    if (RD !== 32'hCAFE_F00D) begin
      n_err++; $display("FAIL first_write_after_reset: got %h expected %h", RD, 32'hCAFE_F00D);
    end
    WE = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_write_enable();
    test_words();
    test_out_of_range();
    test_misaligned();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
